// File: rtl/cdc_sync_multi.sv
// -----------------------------------------------------------------------------
// cdc_sync_multi
//   Multi-bit level synchroniser. Each of the WIDTH channels is an independent
//   single-bit flop chain that brings a foreign-domain level into clk_dest. An
//   optional per-channel stability filter and an optional edge detector sit
//   behind the chain.
//
// Parameters
//   WIDTH    number of independent channels (1..64)
//   STAGES   flops per synchroniser chain (2..4)
//   FILT     consecutive mismatching cycles before sync_out follows the chain;
//            0 bypasses the filter (0..255)
//   RST_VAL  reset value of every chain stage, prev and sync_out
//
// Ports
//   clk_dest    in   destination clock, rising edge
//   rst         in   asynchronous active-high reset
//   async_in    in   [WIDTH] foreign-domain levels
//   sync_out    out  [WIDTH] synchronised (and filtered) levels
//   rise_pulse  out  [WIDTH] one-cycle pulse on sync_out 0->1
//   fall_pulse  out  [WIDTH] one-cycle pulse on sync_out 1->0
//   changed     out  OR of all rise/fall pulse bits
//
// Build option
//   CDC_SYNC_MULTI_EDGE_EN  when defined, builds the prev register and the
//   pulse logic; when undefined, rise_pulse/fall_pulse/changed are tied low.
// -----------------------------------------------------------------------------
module cdc_sync_multi #(
   parameter int               WIDTH   = 4,
   parameter int               STAGES  = 2,
   parameter int               FILT    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_dest,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             changed
);

   generate
      if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
         $error("cdc_sync_multi: STAGES must be 2..4");
      end
      if (FILT < 0 || FILT > 255) begin : g_bad_filt
         $error("cdc_sync_multi: FILT must be 0..255");
      end
      if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
         $error("cdc_sync_multi: WIDTH must be 1..64");
      end
   endgenerate

   // Plain flop chain: nothing may sit between stages, so that metastability
   // in stage 0 has a full clock period to resolve before it is used.
   logic [WIDTH-1:0] chain_q [STAGES];
   logic [WIDTH-1:0] last_stage;

   always_ff @(posedge clk_dest or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            chain_q[s] <= RST_VAL;
         end
      end else begin
         chain_q[0] <= async_in;
         for (int s = 1; s < STAGES; s++) begin
            chain_q[s] <= chain_q[s-1];
         end
      end
   end

   assign last_stage = chain_q[STAGES-1];

   generate
      if (FILT == 0) begin : g_nofilt
         assign sync_out = last_stage;
      end else begin : g_filt
         localparam int            CW     = $clog2(FILT + 1);
         localparam logic [CW-1:0] CNT_TC = CW'(FILT - 1);

         logic [CW-1:0]    cnt_q [WIDTH];
         logic [CW-1:0]    cnt_d [WIDTH];
         logic [WIDTH-1:0] out_q;
         logic [WIDTH-1:0] out_d;

         // A channel's counter runs only while the chain disagrees with the
         // output; any agreement clears it, so a short pulse leaves no trace.
         // The update lands on the FILT-th consecutive mismatching edge.
         always_comb begin
            out_d = out_q;
            for (int i = 0; i < WIDTH; i++) begin
               cnt_d[i] = '0;
               if (last_stage[i] != out_q[i]) begin
                  if (cnt_q[i] == CNT_TC) begin
                     out_d[i] = last_stage[i];
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end
         end

         always_ff @(posedge clk_dest or posedge rst) begin
            if (rst) begin
               out_q <= RST_VAL;
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               out_q <= out_d;
               cnt_q <= cnt_d;
            end
         end

         assign sync_out = out_q;
      end
   endgenerate

`ifdef CDC_SYNC_MULTI_EDGE_EN
   // prev resets to the same value as sync_out, so no pulse can appear
   // during reset or on the first cycle after release.
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk_dest or posedge rst) begin
      if (rst) begin
         prev_q <= RST_VAL;
      end else begin
         prev_q <= sync_out;
      end
   end

   assign rise_pulse = sync_out & ~prev_q;
   assign fall_pulse = ~sync_out & prev_q;
   assign changed    = |{rise_pulse, fall_pulse};
`else
   assign rise_pulse = '0;
   assign fall_pulse = '0;
   assign changed    = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_sync_multi.sv
module tb_cdc_sync_multi;

`ifdef CDC_SYNC_MULTI_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic clk;
   logic rst;

   // A: WIDTH=4 STAGES=2 FILT=0 RST_VAL=0000
   logic [3:0] in_a, sync_a, rise_a, fall_a;
   logic       chg_a;
   // B: WIDTH=4 STAGES=3 FILT=4 RST_VAL=0000
   logic [3:0] in_b, sync_b, rise_b, fall_b;
   logic       chg_b;
   // C: WIDTH=4 STAGES=2 FILT=0 RST_VAL=1010
   logic [3:0] in_c, sync_c, rise_c, fall_c;
   logic       chg_c;

   int ntests;
   int nfail;

   cdc_sync_multi #(.WIDTH(4), .STAGES(2), .FILT(0), .RST_VAL(4'b0000)) u_a (
      .clk_dest(clk), .rst(rst), .async_in(in_a), .sync_out(sync_a),
      .rise_pulse(rise_a), .fall_pulse(fall_a), .changed(chg_a));

   cdc_sync_multi #(.WIDTH(4), .STAGES(3), .FILT(4), .RST_VAL(4'b0000)) u_b (
      .clk_dest(clk), .rst(rst), .async_in(in_b), .sync_out(sync_b),
      .rise_pulse(rise_b), .fall_pulse(fall_b), .changed(chg_b));

   cdc_sync_multi #(.WIDTH(4), .STAGES(2), .FILT(0), .RST_VAL(4'b1010)) u_c (
      .clk_dest(clk), .rst(rst), .async_in(in_c), .sync_out(sync_c),
      .rise_pulse(rise_c), .fall_pulse(fall_c), .changed(chg_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [12:0] pk(input logic [3:0] s, input logic [3:0] r,
                                      input logic [3:0] f, input logic c);
      return {s, r, f, c};
   endfunction

   task automatic test_reset();
      logic [12:0] exp;
      rst  = 1'b1;
      in_a = 4'b0000;
      in_b = 4'b0000;
      in_c = 4'b1010;
      #2;
      exp = pk(4'b0000, 4'b0000, 4'b0000, 1'b0);
      ntests++;
      if ({sync_a, rise_a, fall_a, chg_a} !== exp) begin
         nfail++;
         $display("FAIL reset_a: got %b expected %b", {sync_a, rise_a, fall_a, chg_a}, exp);
      end
      ntests++;
      if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
         nfail++;
         $display("FAIL reset_b: got %b expected %b", {sync_b, rise_b, fall_b, chg_b}, exp);
      end
      exp = pk(4'b1010, 4'b0000, 4'b0000, 1'b0);
      ntests++;
      if ({sync_c, rise_c, fall_c, chg_c} !== exp) begin
         nfail++;
         $display("FAIL reset_c: got %b expected %b", {sync_c, rise_c, fall_c, chg_c}, exp);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      ntests++;
      if ({rise_a, fall_a, chg_a, rise_b, fall_b, chg_b, rise_c, fall_c, chg_c} !== 27'd0) begin
         nfail++;
         $display("FAIL reset_first_cycle_pulses: got %b expected 0",
                  {rise_a, fall_a, chg_a, rise_b, fall_b, chg_b, rise_c, fall_c, chg_c});
      end
      ntests++;
      if ({sync_a, sync_b, sync_c} !== 12'b0000_0000_1010) begin
         nfail++;
         $display("FAIL reset_first_cycle_sync: got %b expected 000000001010",
                  {sync_a, sync_b, sync_c});
      end
   endtask

   // Unfiltered path: latency of STAGES edges, simultaneous rises/falls.
   task automatic test_basic();
      logic [3:0]  vin  [4];
      logic [3:0]  vold [4];
      logic [12:0] exp;
      vin[0] = 4'b0101; vold[0] = 4'b0000;
      vin[1] = 4'b1111; vold[1] = 4'b0101;
      vin[2] = 4'b0000; vold[2] = 4'b1111;
      vin[3] = 4'b1001; vold[3] = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         in_a = vin[k];
         tick();
         exp = pk(vold[k], 4'b0000, 4'b0000, 1'b0);
         ntests++;
         if ({sync_a, rise_a, fall_a, chg_a} !== exp) begin
            nfail++;
            $display("FAIL basic_edge1 vec %0d: got %b expected %b", k,
                     {sync_a, rise_a, fall_a, chg_a}, exp);
         end
         tick();
         exp = pk(vin[k], EDGE ? (vin[k] & ~vold[k]) : 4'b0000,
                  EDGE ? (~vin[k] & vold[k]) : 4'b0000, EDGE);
         ntests++;
         if ({sync_a, rise_a, fall_a, chg_a} !== exp) begin
            nfail++;
            $display("FAIL basic_edge2 vec %0d: got %b expected %b", k,
                     {sync_a, rise_a, fall_a, chg_a}, exp);
         end
         tick();
         exp = pk(vin[k], 4'b0000, 4'b0000, 1'b0);
         ntests++;
         if ({sync_a, rise_a, fall_a, chg_a} !== exp) begin
            nfail++;
            $display("FAIL basic_edge3 vec %0d: got %b expected %b", k,
                     {sync_a, rise_a, fall_a, chg_a}, exp);
         end
      end
   endtask

   // STAGES=3, FILT=4: output follows on edge 7, not edge 6.
   task automatic test_filter();
      logic [12:0] exp;
      in_b = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp = pk(4'b0000, 4'b0000, 4'b0000, 1'b0);
         ntests++;
         if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
            nfail++;
            $display("FAIL filter_wait edge %0d: got %b expected %b", k,
                     {sync_b, rise_b, fall_b, chg_b}, exp);
         end
      end
      tick();
      exp = pk(4'b0001, EDGE ? 4'b0001 : 4'b0000, 4'b0000, EDGE);
      ntests++;
      if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
         nfail++;
         $display("FAIL filter_edge7: got %b expected %b", {sync_b, rise_b, fall_b, chg_b}, exp);
      end
      tick();
      exp = pk(4'b0001, 4'b0000, 4'b0000, 1'b0);
      ntests++;
      if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
         nfail++;
         $display("FAIL filter_edge8: got %b expected %b", {sync_b, rise_b, fall_b, chg_b}, exp);
      end
   endtask

   // 3-cycle glitch on channel 1 is swallowed; the following real change
   // still needs the full 7 edges, which shows the counter restarted at 0.
   task automatic test_glitch();
      logic [12:0] exp;
      in_b = 4'b0011;
      tick();
      tick();
      tick();
      in_b = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp = pk(4'b0001, 4'b0000, 4'b0000, 1'b0);
         ntests++;
         if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
            nfail++;
            $display("FAIL glitch_hold cycle %0d: got %b expected %b", k,
                     {sync_b, rise_b, fall_b, chg_b}, exp);
         end
      end
      in_b = 4'b0011;
      for (int k = 1; k <= 6; k++) begin
         tick();
         ntests++;
         if (sync_b !== 4'b0001) begin
            nfail++;
            $display("FAIL glitch_refill edge %0d: got %b expected 0001", k, sync_b);
         end
      end
      tick();
      exp = pk(4'b0011, EDGE ? 4'b0010 : 4'b0000, 4'b0000, EDGE);
      ntests++;
      if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
         nfail++;
         $display("FAIL glitch_refill_edge7: got %b expected %b",
                  {sync_b, rise_b, fall_b, chg_b}, exp);
      end
   endtask

   // Channel 0 falls; reset hits with its counter at 2.
   task automatic test_reset_mid_filter();
      logic [12:0] exp;
      in_b = 4'b0010;
      for (int k = 1; k <= 5; k++) begin
         tick();
         exp = pk(4'b0011, 4'b0000, 4'b0000, 1'b0);
         ntests++;
         if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
            nfail++;
            $display("FAIL midrst_count edge %0d: got %b expected %b", k,
                     {sync_b, rise_b, fall_b, chg_b}, exp);
         end
      end
      #3;
      rst  = 1'b1;
      in_b = 4'b0000;
      #1;
      exp = pk(4'b0000, 4'b0000, 4'b0000, 1'b0);
      ntests++;
      if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
         nfail++;
         $display("FAIL midrst_assert: got %b expected %b", {sync_b, rise_b, fall_b, chg_b}, exp);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         ntests++;
         if ({sync_b, rise_b, fall_b, chg_b} !== exp) begin
            nfail++;
            $display("FAIL midrst_release cycle %0d: got %b expected %b", k,
                     {sync_b, rise_b, fall_b, chg_b}, exp);
         end
      end
   endtask

   // Non-zero RST_VAL, reset asserted between clock edges.
   task automatic test_rst_val();
      logic [12:0] exp;
      in_c = 4'b0101;
      tick();
      tick();
      exp = pk(4'b0101, EDGE ? 4'b0101 : 4'b0000, EDGE ? 4'b1010 : 4'b0000, EDGE);
      ntests++;
      if ({sync_c, rise_c, fall_c, chg_c} !== exp) begin
         nfail++;
         $display("FAIL rstval_swap: got %b expected %b", {sync_c, rise_c, fall_c, chg_c}, exp);
      end
      tick();
      #3;
      rst  = 1'b1;
      in_c = 4'b1010;
      #1;
      exp = pk(4'b1010, 4'b0000, 4'b0000, 1'b0);
      ntests++;
      if ({sync_c, rise_c, fall_c, chg_c} !== exp) begin
         nfail++;
         $display("FAIL rstval_immediate: got %b expected %b", {sync_c, rise_c, fall_c, chg_c}, exp);
      end
      tick();
      tick();
      ntests++;
      if ({sync_c, rise_c, fall_c, chg_c} !== exp) begin
         nfail++;
         $display("FAIL rstval_held: got %b expected %b", {sync_c, rise_c, fall_c, chg_c}, exp);
      end
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         ntests++;
         if ({sync_c, rise_c, fall_c, chg_c} !== exp) begin
            nfail++;
            $display("FAIL rstval_release cycle %0d: got %b expected %b", k,
                     {sync_c, rise_c, fall_c, chg_c}, exp);
         end
      end
   endtask

   initial begin
      ntests = 0;
      nfail  = 0;
      test_reset();
      test_basic();
      test_filter();
      test_glitch();
      test_reset_mid_filter();
      test_rst_val();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
